// File: rtl/clint.sv
// clint: core-local interruptor. Holds mtime, mtimecmp and msip behind a
// single-outstanding MMIO request/response port and drives the MTIP/MSIP
// pending bits for mip.
// Build option: define CLINT_MSIP_EN to implement the msip register; without
// it offset 0 reads as 0, ignores writes and o_msip is tied low.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1  // core clocks per mtime increment, 1..65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [`CPU_WIDTH-1:0] i_req_addr,
  input  logic [`CPU_WIDTH-1:0] i_req_wdata,
  input  logic [7:0]            i_req_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [`CPU_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mtip,
  output logic                  o_msip
);

  localparam logic [63:0] MSIP_ADDR     = BASE_ADDR + 64'h0000;
  localparam logic [63:0] MTIMECMP_ADDR = BASE_ADDR + 64'h4000;
  localparam logic [63:0] MTIME_ADDR    = BASE_ADDR + 64'hBFF8;
  localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] prescaler;
  logic        tick;
  logic        accept;
  logic        wr_en;
  logic        hit_msip;
  logic        hit_mtimecmp;
  logic        hit_mtime;
  logic [63:0] rd_data;
  logic        rd_err;

  // Sub-doubleword address bits carry no information: all registers are 8-byte aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_req_addr[2:0];

  // Byte-lane merge of write data into an existing 64-bit value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // A new request may enter whenever the response slot is empty or draining.
  assign o_req_ready  = ~o_rsp_valid | i_rsp_ready;
  assign accept       = i_req_valid & o_req_ready;
  assign wr_en        = accept & i_req_wen;
  assign hit_msip     = (i_req_addr[63:3] == MSIP_ADDR[63:3]);
  assign hit_mtimecmp = (i_req_addr[63:3] == MTIMECMP_ADDR[63:3]);
  assign hit_mtime    = (i_req_addr[63:3] == MTIME_ADDR[63:3]);
  assign tick         = (prescaler == PRESC_MAX);

`ifdef CLINT_MSIP_EN
  logic msip;

  // Software-interrupt bit: only bit 0 under strobe 0 is stored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      msip <= 1'b0;
    end else if (wr_en && hit_msip && i_req_wstrb[0]) begin
      msip <= i_req_wdata[0];
    end
  end

  // MSIP pending bit follows msip one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_msip <= 1'b0;
    else       o_msip <= msip;
  end
`else
  assign o_msip = 1'b0;
`endif

  // Read mux on the pre-tick register values; unmapped offsets flag an error.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rd_data = '0;
    rd_err  = 1'b0;
    if (hit_mtime) begin
      rd_data = mtime;
    end else if (hit_mtimecmp) begin
      rd_data = mtimecmp;
    end else if (hit_msip) begin
`ifdef CLINT_MSIP_EN
      rd_data = {63'b0, msip};
`endif
    end else begin
      rd_err = 1'b1;
    end
  end

  // Prescaler: counts 0..TICK_DIV-1, a software mtime write does not disturb it.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (i_rst)     prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 16'd1;
  end

  // mtime: a write beats a same-cycle tick and merges with the un-incremented value.
  always_ff @(posedge i_clk) begin
    if (i_rst)                   mtime <= '0;
    else if (wr_en && hit_mtime) mtime <= merge_bytes(mtime, i_req_wdata, i_req_wstrb);
    else if (tick)               mtime <= mtime + 64'd1;
  end

  // mtimecmp: resets to all ones so nothing fires before software programs it.
  always_ff @(posedge i_clk) begin
    if (i_rst)                      mtimecmp <= '1;
    else if (wr_en && hit_mtimecmp) mtimecmp <= merge_bytes(mtimecmp, i_req_wdata, i_req_wstrb);
  end

  // MTIP pending level: registered unsigned compare of current register values.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_mtip <= 1'b0;
    else       o_mtip <= (mtime >= mtimecmp);
  end

  // Response slot: loaded on acceptance, held until the LSU takes it, dropped on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (accept) begin
      o_rsp_valid <= 1'b1;
      o_rsp_rdata <= i_req_wen ? '0 : rd_data;
      o_rsp_err   <= rd_err;
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor. Holds the machine timer registers (mtime, mtimecmp) and the software-interrupt register (msip), all memory-mapped.
- Drives the MTIP and MSIP pending bits into the CSR file's mip register. The writeback-stage interrupt unit consumes those bits to raise timer interrupts.
- Sits on the LSU's uncached MMIO port behind a single-outstanding request/response handshake.

Parameters:
- BASE_ADDR, 64'h0000_0000_0200_0000: CLINT base address. msip is at +0x0000, mtimecmp at +0x4000, mtime at +0xBFF8.
- TICK_DIV, 1: core clocks per mtime increment. Legal range is 1..65535.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  LSU MMIO request valid.
- o_req_ready  out  1  CLINT can accept a request.
- i_req_wen  in  1  1 = write, 0 = read.
- i_req_addr  in  `CPU_WIDTH  byte address. Must be 8-byte aligned; bits [2:0] are ignored.
- i_req_wdata  in  `CPU_WIDTH  write data.
- i_req_wstrb  in  8  byte write strobes.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  LSU accepts the response.
- o_rsp_rdata  out  `CPU_WIDTH  read data. Value is 0 for writes and for unmapped addresses.
- o_rsp_err  out  1  the address matched no register.
- o_mtip  out  1  timer pending, routed to mip.MTIP.
- o_msip  out  1  software pending, routed to mip.MSIP.

Behaviour:
- Reset (i_rst high at a clock edge) sets the following; there are no asynchronous paths:
  - mtime = 0, prescaler = 0.
  - mtimecmp = all ones, so no spurious interrupt after reset.
  - msip = 0.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_mtip = 0, o_msip = 0.
- Reset asserted while a response is pending drops that response; the LSU must not wait on it.
- Handshake:
  - o_req_ready = !o_rsp_valid | i_rsp_ready.
  - A request is accepted on i_req_valid & o_req_ready.
  - The response is registered: o_rsp_valid rises the cycle after acceptance, with o_rsp_rdata and o_rsp_err valid alongside it.
  - o_rsp_valid stays high, with its data held stable, until i_rsp_ready is high at a clock edge.
  - Back-to-back requests run at 1 per cycle when i_rsp_ready stays high.
- Register writes:
  - Writes take effect at the acceptance edge, byte-masked by i_req_wstrb.
  - msip is a 32-bit register: only bit 0 is stored, and only strobe[0] matters for it. Reads return {63'b0, msip}.
  - A read returns the register value before any same-cycle timer tick.
- Prescaler and mtime:
  - The prescaler counts 0..TICK_DIV-1.
  - When the prescaler is at TICK_DIV-1, it returns to 0 and mtime increments by 1. mtime wraps from 2^64-1 to 0.
  - With TICK_DIV = 1, mtime increments every cycle.
- Simultaneous events:
  - A mtime write in the same cycle as a tick: the written value wins and that tick is lost. The prescaler is unaffected.
  - A partial-strobe write to mtime merges the written bytes with the current, un-incremented value.
- Interrupt outputs:
  - o_mtip is registered: o_mtip <= (mtime >= mtimecmp), an unsigned compare of the current register values. It lags a register change by 1 cycle.
  - o_mtip is level-sensitive. It clears only when software raises mtimecmp above mtime, or writes mtime below it.
  - o_msip is registered and equals msip delayed by 1 cycle.
- Unmapped addresses:
  - Any address in the window other than the three register addresses gives o_rsp_err = 1 and rdata = 0.
  - Writes to unmapped addresses have no side effect.
  - The response still completes the handshake normally.

Optional Feature:
- Macro: CLINT_MSIP_EN.
- Defined: the msip register is implemented as above.
- Undefined: no msip flop. Offset 0 reads as 0 with o_rsp_err = 0, writes to it are ignored, and o_msip is tied to 0.

Test Plan:
- Reset hold, then release with TICK_DIV = 1 and no requests -> after 10 cycles a read of mtime returns 10 plus the cycles elapsed in the read handshake; o_mtip = 0.
- Write mtimecmp = 20 with mtime starting at 0 and TICK_DIV = 1 -> o_mtip rises exactly 1 cycle after mtime reaches 20. A later write of mtimecmp = all ones clears o_mtip 1 cycle after the write.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE with TICK_DIV = 4 -> mtime reads ...FFFF after 4 cycles and 0 after 8 cycles (wrap). Also: a mtime write on a tick cycle keeps the written value, not value+1.
- Hold i_rsp_ready = 0 for 3 cycles while a read response is pending -> o_rsp_valid and o_rsp_rdata stay stable, o_req_ready = 0, and no second request is accepted.
- Read at BASE_ADDR+0x8000 -> o_rsp_err = 1 and rdata = 0. Write with strobe 8'h0F of 64'h1234_5678_9ABC_DEF0 to mtimecmp (all ones) -> it reads back 64'hFFFF_FFFF_9ABC_DEF0.
- With CLINT_MSIP_EN defined, write msip = 1 -> o_msip = 1 one cycle later. With the macro undefined, the same write leaves o_msip = 0 and a read returns 0.
